// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache:
// load/store encodings, FSM states and block geometry.
package dcache_pkg;

    localparam int BLOCK_BITS      = 128;
    localparam int WORD_BITS       = 32;
    localparam int OFFSET_BITS     = 4;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } store_size_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2,
        ST_UPDATE    = 2'd3
    } dcache_state_e;

endpackage

// File: rtl/dcache_if.sv
// CPU-side request bus and block-wide main-memory port of the data cache.
// slave = cache side, master = CPU pipeline plus main memory.
interface dcache_if #(
    parameter int ADDR_W = 32
);
    logic [3:0]        memReadEn;
    logic [2:0]        memWriteEn;
    logic [ADDR_W-1:0] DATA_CACHE_ADDR;
    logic [31:0]       DATA_CACHE_DATA;
    logic [31:0]       DATA_CACHE_READ_DATA;
    logic              DATA_CACHE_BUSY_WAIT;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-5:0] mem_address;
    logic [127:0]      mem_writedata;
    logic [127:0]      mem_readdata;
    logic              mem_busywait;

    modport slave (
        input  memReadEn, memWriteEn, DATA_CACHE_ADDR, DATA_CACHE_DATA,
        input  mem_readdata, mem_busywait,
        output DATA_CACHE_READ_DATA, DATA_CACHE_BUSY_WAIT,
        output mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output memReadEn, memWriteEn, DATA_CACHE_ADDR, DATA_CACHE_DATA,
        output mem_readdata, mem_busywait,
        input  DATA_CACHE_READ_DATA, DATA_CACHE_BUSY_WAIT,
        input  mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_byte_lane.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// store merge of a byte/half/word into an existing 32-bit word.
module dcache_byte_lane
    import dcache_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_store_data,
    input  logic [1:0]  i_size,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_load_data = {24'h0, w_byte};
            F3_LHU:  o_load_data = {16'h0, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Misaligned halfword/word stores are aligned down, matching loads.
    always_comb begin
        o_merged_word = i_word;
        case (i_size)
            SZ_B: o_merged_word[{i_offset, 3'b000} +: 8] = i_store_data[7:0];
            SZ_H: begin
                if (i_offset[1]) o_merged_word[31:16] = i_store_data[15:0];
                else             o_merged_word[15:0]  = i_store_data[15:0];
            end
            SZ_W:    o_merged_word = i_store_data;
            default: o_merged_word = i_word;
        endcase
    end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with zero-stall hits.
// Optional hit/miss counters when DCACHE_STATS_EN is defined.
//   state     | meaning
//   IDLE      | serve hits combinationally, launch refill on miss
//   WRITEBACK | dirty victim block being written to main memory
//   FETCH     | requested block being read from main memory
//   UPDATE    | refill block installed, request replays as a hit
module data_cache
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_W     = 32
) (
    input  logic  CLK,
    input  logic  RESET,
    dcache_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS;

    logic [BLOCK_BITS-1:0] r_data [LINES];
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [BLOCK_BITS-1:0] r_fill;

    dcache_state_e         r_state;
    logic                  r_seen_busy;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_W-5:0]     r_mem_address;
    logic [BLOCK_BITS-1:0] r_mem_writedata;
    logic [31:0]           r_read_data;

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_req;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_word;
    logic [BLOCK_BITS-1:0] w_line;
    logic [31:0]           w_old_word;
    logic [31:0]           w_load;
    logic [31:0]           w_new_word;
    logic [BLOCK_BITS-1:0] w_merged_line;
    logic                  w_hit;
    logic                  w_idle;
    logic                  w_rd_hit;
    logic                  w_wr_hit;
    logic                  w_miss;
    logic                  w_xfer_done;

    // A simultaneous read and write is illegal; the read wins.
    assign w_rd        = bus.memReadEn[3];
    assign w_wr        = bus.memWriteEn[2] & ~w_rd;
    assign w_req       = w_rd | w_wr;
    assign w_index     = bus.DATA_CACHE_ADDR[OFFSET_BITS +: INDEX_BITS];
    assign w_tag       = bus.DATA_CACHE_ADDR[ADDR_W-1 -: TAG_W];
    assign w_word      = bus.DATA_CACHE_ADDR[3:2];
    assign w_line      = r_data[w_index];
    assign w_old_word  = w_line[{w_word, 5'b00000} +: 32];
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_idle      = (r_state == ST_IDLE);
    assign w_rd_hit    = w_idle && w_rd && w_hit;
    assign w_wr_hit    = w_idle && w_wr && w_hit;
    assign w_miss      = w_idle && w_req && !w_hit;
    assign w_xfer_done = r_seen_busy && !bus.mem_busywait;

    dcache_byte_lane u_byte_lane (
        .i_word        (w_old_word),
        .i_offset      (bus.DATA_CACHE_ADDR[1:0]),
        .i_funct3      (bus.memReadEn[2:0]),
        .i_store_data  (bus.DATA_CACHE_DATA),
        .i_size        (bus.memWriteEn[1:0]),
        .o_load_data   (w_load),
        .o_merged_word (w_new_word)
    );

    always_comb begin
        w_merged_line = w_line;
        w_merged_line[{w_word, 5'b00000} +: 32] = w_new_word;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state         <= ST_IDLE;
            r_valid         <= '0;
            r_dirty         <= '0;
            r_seen_busy     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_read_data     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_hit) r_read_data <= w_load;
                    if (w_wr_hit) r_dirty[w_index] <= 1'b1;
                    if (w_miss) begin
                        r_seen_busy <= 1'b0;
                        if (r_valid[w_index] && r_dirty[w_index]) begin
                            r_state         <= ST_WRITEBACK;
                            r_mem_write     <= 1'b1;
                            r_mem_address   <= {r_tag[w_index], w_index};
                            r_mem_writedata <= w_line;
                        end else begin
                            r_state       <= ST_FETCH;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= bus.DATA_CACHE_ADDR[ADDR_W-1:4];
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.mem_busywait) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy   <= 1'b0;
                        r_state       <= ST_FETCH;
                        r_mem_write   <= 1'b0;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= bus.DATA_CACHE_ADDR[ADDR_W-1:4];
                    end
                end
                ST_FETCH: begin
                    if (bus.mem_busywait) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy <= 1'b0;
                        r_state     <= ST_UPDATE;
                        r_mem_read  <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    r_valid[w_index] <= 1'b1;
                    r_dirty[w_index] <= 1'b0;
                    r_state          <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Data and tag storage carry no reset; validity alone qualifies them.
    always_ff @(posedge CLK) begin
        if (r_state == ST_FETCH && w_xfer_done) r_fill <= bus.mem_readdata;
        if (w_wr_hit) r_data[w_index] <= w_merged_line;
        if (r_state == ST_UPDATE) begin
            r_data[w_index] <= r_fill;
            r_tag[w_index]  <= w_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic r_stalled;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
            r_stalled  <= 1'b0;
        end else begin
            if (w_miss) begin
                r_stalled <= 1'b1;
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
            if (w_idle && w_req && w_hit) begin
                r_stalled <= 1'b0;
                if (!r_stalled && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end
        end
    end
`endif

    assign bus.DATA_CACHE_BUSY_WAIT = RESET && (!w_idle || w_miss);
    assign bus.DATA_CACHE_READ_DATA = w_rd_hit ? w_load : r_read_data;
    assign bus.mem_read             = r_mem_read;
    assign bus.mem_write            = r_mem_write;
    assign bus.mem_address          = r_mem_address;
    assign bus.mem_writedata        = r_mem_writedata;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: CPU request sequence plus a 3-busy-cycle
// main-memory responder backed by an associative block store.
module tb_data_cache;
    import dcache_pkg::*;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    dcache_if #(.ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    data_cache #(.INDEX_BITS(3), .ADDR_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_err = 0;
    int n_chk = 0;

    logic [127:0] mem [int];
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    logic [27:0]  last_rd_addr = '0;
    logic [27:0]  last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;
    logic [27:0]  resp_addr;
    logic         resp_wr;

    function automatic logic [127:0] default_block(input logic [27:0] blk);
        logic [31:0] base;
        base = 32'hA000_0000 | {blk, 4'h0};
        return {base | 32'd3, base | 32'd2, base | 32'd1, base};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] re, input logic [2:0] we,
                         input logic [31:0] a, input logic [31:0] d);
        bus.memReadEn       = re;
        bus.memWriteEn      = we;
        bus.DATA_CACHE_ADDR = a;
        bus.DATA_CACHE_DATA = d;
    endtask

    // Returns on a falling edge with BUSY_WAIT low (or the budget spent).
    task automatic wait_done(input string tag, output logic missed);
        int cyc;
        @(negedge CLK);
        missed = bus.DATA_CACHE_BUSY_WAIT;
        cyc = 0;
        while (bus.DATA_CACHE_BUSY_WAIT && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        chk({tag, "_done"}, bus.DATA_CACHE_BUSY_WAIT, 1'b0);
    endtask

    // Called at posedge+1; returns at the following posedge+1 with the bus idle.
    task automatic access(input string tag, input logic [3:0] re, input logic [2:0] we,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_miss, input logic chk_rd, input logic [31:0] exp_rd);
        logic missed;
        drive(re, we, a, d);
        wait_done(tag, missed);
        chk({tag, "_stall"}, missed, exp_miss);
        if (chk_rd) chk({tag, "_rdata"}, bus.DATA_CACHE_READ_DATA, exp_rd);
        @(posedge CLK);
        #1;
        drive(4'b0, 3'b0, 32'h0, 32'h0);
    endtask

    // Main memory: every transfer holds mem_busywait high for 3 cycles.
    initial begin
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = '0;
        mem[4] = 128'h0403_0201_1122_3344_5566_7788_8765_4321;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.mem_read || bus.mem_write) begin
                resp_addr = bus.mem_address;
                resp_wr   = bus.mem_write;
                if (resp_wr) begin
                    wr_cnt++;
                    last_wr_addr = resp_addr;
                    last_wr_data = bus.mem_writedata;
                end else begin
                    rd_cnt++;
                    last_rd_addr = resp_addr;
                end
                bus.mem_busywait = 1'b1;
                repeat (3) @(posedge CLK);
                #1;
                if (resp_wr) mem[int'(resp_addr)] = last_wr_data;
                else bus.mem_readdata = mem.exists(int'(resp_addr)) ? mem[int'(resp_addr)]
                                                                     : default_block(resp_addr);
                bus.mem_busywait = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic missed;
        int cyc;
        drive(4'b0, 3'b0, 32'h0, 32'h0);

        // Reset state
        #12;
        chk("rst_busy", bus.DATA_CACHE_BUSY_WAIT, 1'b0);
        chk("rst_rdata", bus.DATA_CACHE_READ_DATA, 32'h0);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // First miss: LW 0x40, clean victim, straight to FETCH
        drive(4'b1010, 3'b000, 32'h0000_0040, 32'h0);
        @(negedge CLK);
        chk("miss_busy_comb", bus.DATA_CACHE_BUSY_WAIT, 1'b1);
        chk("miss_mem_read_early", bus.mem_read, 1'b0);
        @(negedge CLK);
        chk("fetch_mem_read", bus.mem_read, 1'b1);
        chk("fetch_mem_write", bus.mem_write, 1'b0);
        chk("fetch_addr", bus.mem_address, 28'h000_0004);
        wait_done("lw40_miss", missed);
        chk("lw40_rdata", bus.DATA_CACHE_READ_DATA, 32'h8765_4321);
        chk("lw40_no_wb", wr_cnt, 0);
        chk("lw40_rd_cnt", rd_cnt, 1);
        @(posedge CLK);
        #1;
        drive(4'b0, 3'b0, 32'h0, 32'h0);

        // Zero-stall hits: store byte then loads of the same line
        access("sb41",  4'b0000, 3'b100, 32'h41, 32'h0000_00AB, 1'b0, 1'b0, 32'h0);
        access("lbu41", 4'b1100, 3'b000, 32'h41, 32'h0, 1'b0, 1'b1, 32'h0000_00AB);
        access("lb41",  4'b1000, 3'b000, 32'h41, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFAB);
        access("lw40",  4'b1010, 3'b000, 32'h40, 32'h0, 1'b0, 1'b1, 32'h8765_AB21);
        access("lh40",  4'b1001, 3'b000, 32'h40, 32'h0, 1'b0, 1'b1, 32'hFFFF_AB21);
        access("lhu42", 4'b1101, 3'b000, 32'h42, 32'h0, 1'b0, 1'b1, 32'h0000_8765);
        access("lw43",  4'b1010, 3'b000, 32'h43, 32'h0, 1'b0, 1'b1, 32'h8765_AB21);
        access("lw48",  4'b1010, 3'b000, 32'h48, 32'h0, 1'b0, 1'b1, 32'h1122_3344);

        // Conflict miss on index 4 evicts the dirty line first
        access("lwc0", 4'b1010, 3'b000, 32'hC0, 32'h0, 1'b1, 1'b1, 32'hA000_00C0);
        chk("wb_count", wr_cnt, 1);
        chk("wb_addr", last_wr_addr, 28'h000_0004);
        chk("wb_word0", last_wr_data[31:0], 32'h8765_AB21);
        chk("wb_word1", last_wr_data[63:32], 32'h5566_7788);
        chk("wb_then_fetch", rd_cnt, 2);
        chk("wb_fetch_addr", last_rd_addr, 28'h000_000C);

        // Store-miss allocates, then halfword stores/loads
        access("sh46",  4'b0000, 3'b101, 32'h46, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0);
        chk("sh46_clean_evict", wr_cnt, 1);
        access("lh46",  4'b1001, 3'b000, 32'h46, 32'h0, 1'b0, 1'b1, 32'hFFFF_BEEF);
        access("lhu46", 4'b1101, 3'b000, 32'h46, 32'h0, 1'b0, 1'b1, 32'h0000_BEEF);
        access("lw44",  4'b1010, 3'b000, 32'h44, 32'h0, 1'b0, 1'b1, 32'hBEEF_7788);
        access("lw40_rt", 4'b1010, 3'b000, 32'h40, 32'h0, 1'b0, 1'b1, 32'h8765_AB21);

        // Reset asserted during FETCH
        drive(4'b1010, 3'b000, 32'h0000_0100, 32'h0);
        cyc = 0;
        @(negedge CLK);
        while (!bus.mem_read && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("rstmid_fetch_seen", bus.mem_read, 1'b1);
        #2;
        RESET = 1'b0;
        #1;
        chk("rstmid_mem_read", bus.mem_read, 1'b0);
        chk("rstmid_mem_write", bus.mem_write, 1'b0);
        chk("rstmid_busy", bus.DATA_CACHE_BUSY_WAIT, 1'b0);
        chk("rstmid_rdata", bus.DATA_CACHE_READ_DATA, 32'h0);
        drive(4'b0, 3'b0, 32'h0, 32'h0);
        cyc = 0;
        while (bus.mem_busywait && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("rstmid_mem_idle", bus.mem_busywait, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Lines are invalid again; dirty SH data was dropped by reset
        access("lw100_re", 4'b1010, 3'b000, 32'h100, 32'h0, 1'b1, 1'b1, 32'hA000_0100);
        access("lw40_re",  4'b1010, 3'b000, 32'h40,  32'h0, 1'b1, 1'b1, 32'h8765_AB21);
        access("h_lw100",  4'b1010, 3'b000, 32'h100, 32'h0, 1'b0, 1'b1, 32'hA000_0100);
        access("h_lw40",   4'b1010, 3'b000, 32'h40,  32'h0, 1'b0, 1'b1, 32'h8765_AB21);
        access("h_lbu43",  4'b1100, 3'b000, 32'h43,  32'h0, 1'b0, 1'b1, 32'h0000_0087);
        access("h_lw44",   4'b1010, 3'b000, 32'h44,  32'h0, 1'b0, 1'b1, 32'h5566_7788);
        access("h_sb42",   4'b0000, 3'b100, 32'h42,  32'h0000_0011, 1'b0, 1'b0, 32'h0);
        access("lw40_sb",  4'b1010, 3'b000, 32'h40,  32'h0, 1'b0, 1'b1, 32'h8711_AB21);

`ifdef DCACHE_STATS_EN
        chk("stat_miss", miss_count, 32'd2);
        chk("stat_hit", hit_count, 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
